// File: rtl/trace_capture.sv
// -----------------------------------------------------------------------------
// trace_capture
//
// Purpose:
//   Captures up to NCH retired instructions per cycle into a DEPTH-entry
//   first-word-fall-through FIFO of trace records. Each record holds
//   {pc, we, rd, wdata, seq}.
//
//   Every valid retire channel draws a number from a 32-bit sequence counter,
//   so gaps in trc_seq show where records were dropped. When a cycle presents
//   more candidates than there is free space, the oldest candidates are kept
//   (channel 0 is the oldest). The remaining candidates are dropped, the
//   sticky overflow flag is set, and the saturating drop_cnt is increased by
//   the number dropped.
//
//   Optional feature (macro TRACE_WB_FILTER_EN):
//     When this macro is defined, only channels that write a non-zero
//     destination register are stored or counted as drops. Filtered channels
//     still advance the sequence counter.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   clr        in   synchronous clear of FIFO, sequence counter and drop state
//   ret_val    in   [NCH]       retire-valid per channel
//   ret_pc     in   [NCH*XLEN]  retired PC per channel
//   ret_we     in   [NCH]       register-write flag per channel
//   ret_rd     in   [NCH*5]     destination register per channel
//   ret_wdata  in   [NCH*XLEN]  register write data per channel
//   trc_val    out  head record valid (FIFO not empty)
//   trc_rdy    in   consumer ready
//   trc_pc/trc_we/trc_rd/trc_wdata/trc_seq  out  head record fields (0 when empty)
//   count      out  occupancy
//   overflow   out  sticky: at least one record dropped
//   drop_cnt   out  saturating count of dropped records
//
// Handshake: the head record is consumed on a rising edge where
//   trc_val && trc_rdy. The head fields stay stable while trc_val=1 and
//   trc_rdy=0. trc_rdy has no effect while the FIFO is empty.
// -----------------------------------------------------------------------------
module trace_capture #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int NCH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [NCH-1:0]           ret_val,
    input  logic [NCH*XLEN-1:0]      ret_pc,
    input  logic [NCH-1:0]           ret_we,
    input  logic [NCH*5-1:0]         ret_rd,
    input  logic [NCH*XLEN-1:0]      ret_wdata,
    output logic                     trc_val,
    input  logic                     trc_rdy,
    output logic [XLEN-1:0]          trc_pc,
    output logic                     trc_we,
    output logic [4:0]               trc_rd,
    output logic [XLEN-1:0]          trc_wdata,
    output logic [31:0]              trc_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Record storage (intentionally not reset)
    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic            we_mem  [DEPTH];
    logic [4:0]      rd_mem  [DEPTH];
    logic [XLEN-1:0] wd_mem  [DEPTH];
    logic [31:0]     seq_mem [DEPTH];

    // State
    logic [CW-1:0] count_q,    count_d;
    logic [AW-1:0] wptr_q,     wptr_d;
    logic [AW-1:0] rptr_q,     rptr_d;
    logic [31:0]   seq_q,      seq_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q,     drop_d;

    // Per-channel write decode
    logic [NCH-1:0]  wr_en;
    logic [NCH-1:0]  cand;
    logic [AW-1:0]   wr_idx [NCH];
    logic [31:0]     wr_seq [NCH];
    logic            wr_we  [NCH];
    logic [4:0]      wr_rd  [NCH];
    logic [XLEN-1:0] wr_wd  [NCH];

    logic [31:0] free_w;
    logic [31:0] n_push;
    logic [31:0] n_drop;
    logic [31:0] n_seq;
    logic        pop;
    logic [16:0] drop_sum;

    // Walk the channels oldest-first. n_push gives the FIFO slot offset of
    // each stored candidate, and n_seq gives its sequence offset. Free space
    // is taken from count_q, so a pop in this cycle does not make room for
    // this cycle's pushes.
    always_comb begin
        free_w = 32'(DEPTH) - 32'(count_q);
        n_push = '0;
        n_drop = '0;
        n_seq  = '0;
        wr_en  = '0;
        cand   = '0;
        for (int k = 0; k < NCH; k++) begin
            wr_idx[k] = wptr_q + n_push[AW-1:0];
            wr_seq[k] = seq_q + n_seq;
            wr_rd[k]  = ret_rd[k*5 +: 5];
            // Writes to x0 are recorded as non-writes with zero data
            wr_we[k]  = ret_we[k] && (ret_rd[k*5 +: 5] != 5'd0);
            wr_wd[k]  = (ret_rd[k*5 +: 5] != 5'd0) ? ret_wdata[k*XLEN +: XLEN] : '0;
`ifdef TRACE_WB_FILTER_EN
            cand[k]   = ret_val[k] && ret_we[k] && (ret_rd[k*5 +: 5] != 5'd0);
`else
            cand[k]   = ret_val[k];
`endif
            if (ret_val[k]) begin
                n_seq = n_seq + 32'd1;
            end
            if (cand[k]) begin
                if (n_push < free_w) begin
                    wr_en[k] = 1'b1;
                    n_push   = n_push + 32'd1;
                end else begin
                    n_drop   = n_drop + 32'd1;
                end
            end
        end
    end

    assign pop      = (count_q != '0) && trc_rdy;
    assign drop_sum = {1'b0, drop_q} + 17'(n_drop);

    always_comb begin
        count_d    = count_q + CW'(n_push) - CW'(pop);
        wptr_d     = wptr_q + AW'(n_push);
        rptr_d     = rptr_q + AW'(pop);
        seq_d      = seq_q + n_seq;
        overflow_d = overflow_q || (n_drop != '0);
        drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (clr) begin
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            seq_d      = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Stored candidates always land in distinct slots, so the writes never collide
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int k = 0; k < NCH; k++) begin
                if (wr_en[k]) begin
                    pc_mem[wr_idx[k]]  <= ret_pc[k*XLEN +: XLEN];
                    we_mem[wr_idx[k]]  <= wr_we[k];
                    rd_mem[wr_idx[k]]  <= wr_rd[k];
                    wd_mem[wr_idx[k]]  <= wr_wd[k];
                    seq_mem[wr_idx[k]] <= wr_seq[k];
                end
            end
        end
    end

    // First-word-fall-through head, forced to zero while empty
    assign trc_val   = (count_q != '0);
    assign trc_pc    = trc_val ? pc_mem[rptr_q]  : '0;
    assign trc_we    = trc_val ? we_mem[rptr_q]  : 1'b0;
    assign trc_rd    = trc_val ? rd_mem[rptr_q]  : '0;
    assign trc_wdata = trc_val ? wd_mem[rptr_q]  : '0;
    assign trc_seq   = trc_val ? seq_mem[rptr_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int NCH   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                   clr;
    logic [NCH-1:0]         ret_val;
    logic [NCH*XLEN-1:0]    ret_pc;
    logic [NCH-1:0]         ret_we;
    logic [NCH*5-1:0]       ret_rd;
    logic [NCH*XLEN-1:0]    ret_wdata;
    logic                   trc_val;
    logic                   trc_rdy;
    logic [XLEN-1:0]        trc_pc;
    logic                   trc_we;
    logic [4:0]             trc_rd;
    logic [XLEN-1:0]        trc_wdata;
    logic [31:0]            trc_seq;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [15:0]            drop_cnt;

    trace_capture #(.XLEN(XLEN), .DEPTH(DEPTH), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .ret_val(ret_val), .ret_pc(ret_pc), .ret_we(ret_we),
        .ret_rd(ret_rd), .ret_wdata(ret_wdata),
        .trc_val(trc_val), .trc_rdy(trc_rdy),
        .trc_pc(trc_pc), .trc_we(trc_we), .trc_rd(trc_rd),
        .trc_wdata(trc_wdata), .trc_seq(trc_seq),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] seq;
    } rec_t;

    rec_t        exp_q[$];
    logic [31:0] m_seq;
    logic        m_ovf;
    int          m_drop;
    int          total = 0;
    int          bad   = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Queue model: pop the head, then append the valid channels in order
    // until the free space measured at the start of the cycle runs out.
    always @(posedge clk or posedge rst) begin : model
        int   free_n, stored, dropped;
        bit   keep;
        rec_t r;
        if (rst || clr) begin
            exp_q.delete();
            m_seq  = 0;
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            free_n  = DEPTH - exp_q.size();
            stored  = 0;
            dropped = 0;
            if (exp_q.size() != 0 && trc_rdy) void'(exp_q.pop_front());
            for (int k = 0; k < NCH; k++) begin
                if (ret_val[k]) begin
                    r.pc  = ret_pc[k*XLEN +: XLEN];
                    r.rd  = ret_rd[k*5 +: 5];
                    r.we  = (r.rd != 0) ? ret_we[k] : 1'b0;
                    r.wd  = (r.rd != 0) ? ret_wdata[k*XLEN +: XLEN] : 32'd0;
                    r.seq = m_seq;
`ifdef TRACE_WB_FILTER_EN
                    keep = ret_we[k] && (r.rd != 0);
`else
                    keep = 1'b1;
`endif
                    if (keep) begin
                        if (stored < free_n) begin
                            exp_q.push_back(r);
                            stored++;
                        end else begin
                            dropped++;
                        end
                    end
                    m_seq = m_seq + 32'd1;
                end
            end
            if (dropped != 0) m_ovf = 1'b1;
            m_drop = (m_drop + dropped > 65535) ? 65535 : m_drop + dropped;
        end
    end

    // Per-cycle compare on the falling edge
    always @(negedge clk) begin : compare
        rec_t h;
        if (!rst) begin
            h = (exp_q.size() != 0) ? exp_q[0] : '0;
            chk("count",     64'(count),     64'(exp_q.size()));
            chk("trc_val",   64'(trc_val),   64'(exp_q.size() != 0));
            chk("trc_pc",    64'(trc_pc),    64'(h.pc));
            chk("trc_we",    64'(trc_we),    64'(h.we));
            chk("trc_rd",    64'(trc_rd),    64'(h.rd));
            chk("trc_wdata", 64'(trc_wdata), 64'(h.wd));
            chk("trc_seq",   64'(trc_seq),   64'(h.seq));
            chk("overflow",  64'(overflow),  64'(m_ovf));
            chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ch(input int k, input logic [31:0] pc, input logic we,
                          input logic [4:0] rd, input logic [31:0] wd);
        ret_pc[k*XLEN +: XLEN]    = pc;
        ret_we[k]                 = we;
        ret_rd[k*5 +: 5]          = rd;
        ret_wdata[k*XLEN +: XLEN] = wd;
    endtask

    task automatic push(input logic [1:0] v, input logic [31:0] pc);
        set_ch(0, pc,      1'b1, 5'd1, pc ^ 32'h5555);
        set_ch(1, pc + 4,  1'b1, 5'd2, pc ^ 32'hAAAA);
        ret_val = v;
        step();
        ret_val = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr = 0; ret_val = '0; ret_pc = '0; ret_we = '0; ret_rd = '0;
        ret_wdata = '0; trc_rdy = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_val",      64'(trc_val),  64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop",     64'(drop_cnt), 64'd0);

        // Two channels into an empty FIFO
        push(2'b11, 32'h100);
        chk("dual_count", 64'(count),   64'd2);
        chk("dual_pc0",   64'(trc_pc),  64'h100);
        chk("dual_seq0",  64'(trc_seq), 64'd0);
        trc_rdy = 1;
        step();
        chk("dual_pc1",   64'(trc_pc),  64'h104);
        chk("dual_seq1",  64'(trc_seq), 64'd1);
        step();
        trc_rdy = 0;
        chk("dual_empty", 64'(count),   64'd0);

        // Overflow: count=3 with two candidates
        push(2'b11, 32'h200);             // seq 2,3
        push(2'b01, 32'h208);             // seq 4
        chk("ovf_pre", 64'(count), 64'd3);
        push(2'b11, 32'h20C);             // seq 5 stored, seq 6 dropped
        chk("ovf_count", 64'(count),    64'd4);
        chk("ovf_flag",  64'(overflow), 64'd1);
        chk("ovf_drop",  64'(drop_cnt), 64'd1);

        // Full with pop: the pop does not make room for this cycle's push
        trc_rdy = 1;
        push(2'b01, 32'h214);             // seq 7 dropped, seq 2 popped
        chk("full_count", 64'(count),    64'd3);
        chk("full_drop",  64'(drop_cnt), 64'd2);
        chk("full_head",  64'(trc_seq),  64'd3);
        push(2'b01, 32'h218);             // seq 8 stored, seq 3 popped
        step();                           // seq 4 popped
        step();                           // seq 5 popped
        chk("gap_seq",    64'(trc_seq),  64'd8);
        chk("gap_pc",     64'(trc_pc),   64'h218);
        step();
        trc_rdy = 0;

        // Write to x0 is recorded without write-enable or data
        set_ch(0, 32'h300, 1'b1, 5'd0, 32'hDEAD);
        ret_val = 2'b01;
        step();                           // seq 9
        ret_val = '0;
`ifdef TRACE_WB_FILTER_EN
        chk("x0_filtered", 64'(count), 64'd0);
`else
        chk("x0_count", 64'(count),     64'd1);
        chk("x0_we",    64'(trc_we),    64'd0);
        chk("x0_wdata", 64'(trc_wdata), 64'd0);
        chk("x0_seq",   64'(trc_seq),   64'd9);
`endif
        trc_rdy = 1;
        set_ch(0, 32'h304, 1'b1, 5'd3, 32'h55);
        ret_val = 2'b01;
        step();                           // seq 10
        ret_val = '0;
        chk("x0_next_seq", 64'(trc_seq),   64'd10);
        chk("x0_next_wd",  64'(trc_wdata), 64'h55);
        step();
        trc_rdy = 0;

        // Asynchronous reset while holding three records
        push(2'b11, 32'h400);
        push(2'b01, 32'h408);
        chk("arst_pre", 64'(count), 64'd3);
        #2 rst = 1;
        #1;
        chk("arst_count", 64'(count),   64'd0);
        chk("arst_val",   64'(trc_val), 64'd0);
        @(negedge clk);
        #3 rst = 0;
        @(negedge clk);
        push(2'b01, 32'h500);
        chk("arst_seq", 64'(trc_seq), 64'd0);
        chk("arst_cnt", 64'(count),   64'd1);

        // Clear wins over push and pop
        push(2'b11, 32'h600);
        push(2'b11, 32'h608);             // one dropped
        chk("clr_pre_ovf", 64'(overflow), 64'd1);
        clr = 1; trc_rdy = 1;
        push(2'b01, 32'h700);
        clr = 0; trc_rdy = 0;
        chk("clr_count", 64'(count),    64'd0);
        chk("clr_ovf",   64'(overflow), 64'd0);
        chk("clr_drop",  64'(drop_cnt), 64'd0);
        chk("clr_val",   64'(trc_val),  64'd0);
        push(2'b01, 32'h800);
        chk("clr_seq",   64'(trc_seq),  64'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NCH; k++)
                set_ch(k, $urandom, 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)), $urandom);
            ret_val = 2'($urandom_range(0, 3));
            trc_rdy = ($urandom_range(0, 1) == 1);
            clr     = ($urandom_range(0, 99) == 0);
            step();
        end
        clr = 0; ret_val = '0; trc_rdy = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
